// File: rtl/ps2_key_event_queue.sv
// PS/2 byte-stream parser (E0/F0 prefixes) with a 512-key down map and a FWFT event FIFO.
// Optional build macro: TYPEMATIC_FILTER_EN drops auto-repeat makes for keys already held.
module ps2_key_event_queue #(
  parameter int          FIFO_DEPTH = 8,
  parameter int          OVF_CNT_W  = 8,
  parameter logic [7:0]  INIT_CODE  = 8'hAA
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          byte_valid,
  input  logic [7:0]                    byte_data,
  output logic                          ev_valid,
  input  logic                          ev_ready,
  output logic [9:0]                    ev_data,
  output logic [511:0]                  key_down,
  output logic                          any_down,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic [OVF_CNT_W-1:0]          ovf_count,
  output logic                          kbd_ready
);

  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int LVL_W = AW + 1;

  typedef struct packed {
    logic       ext;
    logic       brk;
    logic [7:0] code;
  } ev_t;

  typedef enum logic [2:0] {
    S_WAIT_INIT,
    S_IDLE,
    S_EXT,
    S_BRK,
    S_EXT_BRK
  } state_t;

  state_t state, state_nxt;

  logic is_e0, is_f0, is_err, is_init;
  assign is_e0   = (byte_data == 8'hE0);
  assign is_f0   = (byte_data == 8'hF0);
  assign is_err  = (byte_data == 8'h00) || (byte_data == 8'hFF);
  assign is_init = (byte_data == INIT_CODE);

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_WAIT_INIT;
    else      state <= state_nxt;
  end

  // Next-state logic; the parser only advances on a byte strobe
  always_comb begin
    state_nxt = state;
    if (byte_valid) begin
      unique case (state)
        S_WAIT_INIT: if (is_init) state_nxt = S_IDLE;
        S_IDLE: begin
          if (is_e0)      state_nxt = S_EXT;
          else if (is_f0) state_nxt = S_BRK;
        end
        S_EXT: begin
          if (is_f0)      state_nxt = S_EXT_BRK;
          else if (!is_e0) state_nxt = S_IDLE;
        end
        S_BRK, S_EXT_BRK: state_nxt = S_IDLE;
        default:          state_nxt = S_WAIT_INIT;
      endcase
    end
  end

  // Output decode: which event (if any) this byte produces
  logic emit, em_ext, em_brk, arm, kd_clr;
  always_comb begin
    emit   = 1'b0;
    em_ext = 1'b0;
    em_brk = 1'b0;
    arm    = 1'b0;
    kd_clr = 1'b0;
    if (byte_valid) begin
      unique case (state)
        S_WAIT_INIT: arm = is_init;
        S_IDLE: begin
          if (!is_e0 && !is_f0) begin
            if (is_init)      kd_clr = 1'b1;
            else if (!is_err) emit   = 1'b1;
          end
        end
        S_EXT: begin
          emit   = !is_e0 && !is_f0 && !is_err;
          em_ext = 1'b1;
        end
        S_BRK: begin
          emit   = !is_e0 && !is_f0 && !is_err;
          em_brk = 1'b1;
        end
        S_EXT_BRK: begin
          emit   = !is_e0 && !is_f0 && !is_err;
          em_ext = 1'b1;
          em_brk = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)     kbd_ready <= 1'b0;
    else if (arm) kbd_ready <= 1'b1;
  end

  logic [8:0] kd_idx;
  logic       kd_hit;
  assign kd_idx = {em_ext, byte_data};
  assign kd_hit = key_down[kd_idx];

  // A break to a key already up simply rewrites a zero
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)        key_down <= '0;
    else if (kd_clr) key_down <= '0;
    else if (emit)   key_down[kd_idx] <= ~em_brk;
  end

  assign any_down = |key_down;

  logic push_req;
`ifdef TYPEMATIC_FILTER_EN
  assign push_req = emit && !(!em_brk && kd_hit);
`else
  assign push_req = emit;
  logic unused_hit;
  assign unused_hit = kd_hit;
`endif

  ev_t new_ev;
  assign new_ev = '{ext: em_ext, brk: em_brk, code: byte_data};

  logic                         full, pop, push, drop;
  logic [AW-1:0]                rd_ptr, wr_ptr;
  logic [FIFO_DEPTH-1:0][9:0]   mem;

  assign ev_valid = (fifo_level != '0);
  assign full     = (fifo_level == LVL_W'(FIFO_DEPTH));
  assign pop      = ev_valid && ev_ready;
  // A pop in the same cycle frees the slot, so a full FIFO can still take a push
  assign push     = push_req && (!full || pop);
  assign drop     = push_req && full && !pop;
  assign ev_data  = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem        <= '0;
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      fifo_level <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= new_ev;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      fifo_level <= fifo_level + 1'b1;
      else if (pop && !push) fifo_level <= fifo_level - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                         ovf_count <= '0;
    else if (drop && ovf_count != '1) ovf_count <= ovf_count + 1'b1;
  end

endmodule

// File: tb/tb_ps2_key_event_queue.sv
// Scoreboard bench for ps2_key_event_queue: stimulus queues expected events, a monitor pops them.
module tb_ps2_key_event_queue;

  logic         clk, rst, byte_valid, ev_valid, ev_ready, any_down, kbd_ready;
  logic [7:0]   byte_data;
  logic [9:0]   ev_data;
  logic [511:0] key_down;
  logic [3:0]   fifo_level;
  logic [7:0]   ovf_count;

  int checks   = 0;
  int failures = 0;
  logic [9:0] exp_q[$];

  ps2_key_event_queue #(.FIFO_DEPTH(8), .OVF_CNT_W(8), .INIT_CODE(8'hAA)) dut (
    .clk(clk), .rst(rst), .byte_valid(byte_valid), .byte_data(byte_data),
    .ev_valid(ev_valid), .ev_ready(ev_ready), .ev_data(ev_data),
    .key_down(key_down), .any_down(any_down), .fifo_level(fifo_level),
    .ovf_count(ovf_count), .kbd_ready(kbd_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  // Monitor: a handshake seen at the negedge completes at the following posedge
  always @(negedge clk) begin
    if (rst && ev_valid && ev_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_event: got %h, expected none", ev_data);
      end else begin
        logic [9:0] e;
        e = exp_q.pop_front();
        if (ev_data !== e) begin
          failures++;
          $display("FAIL event: got %h, expected %h", ev_data, e);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic send(input logic [7:0] b);
    @(posedge clk); #1;
    byte_valid = 1'b1;
    byte_data  = b;
    @(posedge clk); #1;
    byte_valid = 1'b0;
  endtask

  task automatic expect_ev(input logic [9:0] e);
    exp_q.push_back(e);
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 60 && (exp_q.size() != 0 || ev_valid); i++) @(posedge clk);
    #1;
    chk(name, exp_q.size(), 0);
    chk({name, "_level"}, fifo_level, 0);
  endtask

  logic [511:0] kd_exp;
  logic [7:0]   ovf_codes[10];

  initial begin
    rst = 1'b0; byte_valid = 1'b0; byte_data = 8'h00; ev_ready = 1'b0;
    repeat (2) @(posedge clk); #1;
    chk("rst_ev_valid", ev_valid, 0);
    chk("rst_ev_data", ev_data, 0);
    chk("rst_key_down", key_down, 0);
    chk("rst_any_down", any_down, 0);
    chk("rst_level", fifo_level, 0);
    chk("rst_ovf", ovf_count, 0);
    chk("rst_kbd_ready", kbd_ready, 0);
    rst = 1'b1; ev_ready = 1'b1;

    // Init gating
    send(8'h1C);
    chk("pre_init_kbd_ready", kbd_ready, 0);
    chk("pre_init_key_down", key_down, 0);
    send(8'hAA);
    chk("init_kbd_ready", kbd_ready, 1);
    expect_ev(10'h01C); send(8'h1C);
    chk("make_1c_down", key_down[9'h01C], 1);
    chk("make_any_down", any_down, 1);

    // Break
    send(8'hF0); expect_ev(10'h11C); send(8'h1C);
    chk("break_1c_down", key_down[9'h01C], 0);
    chk("break_any_down", any_down, 0);

    // Extended make/break
    send(8'hE0); expect_ev(10'h275); send(8'h75);
    chk("ext_make_down", key_down[9'h175], 1);
    chk("ext_make_plain", key_down[9'h075], 0);
    send(8'hE0); send(8'hF0); expect_ev(10'h375); send(8'h75);
    chk("ext_break_down", key_down[9'h175], 0);

    // Error bytes and broken prefixes emit nothing
    send(8'h00); send(8'hFF); send(8'hF0); send(8'hE0);
    send(8'hE0); send(8'h00);
    expect_ev(10'h01C); send(8'h1C);
    chk("after_err_down", key_down[9'h01C], 1);
    // Keyboard re-init clears the map, no event
    send(8'hAA);
    chk("reinit_any_down", any_down, 0);
    // Break for a key that is up still emits
    send(8'hF0); expect_ev(10'h12A); send(8'h2A);
    chk("orphan_break_down", key_down, 0);
    drain("drain1");

    // Typematic repeat
    expect_ev(10'h01C);
`ifndef TYPEMATIC_FILTER_EN
    expect_ev(10'h01C); expect_ev(10'h01C);
`endif
    send(8'h1C); send(8'h1C); send(8'h1C);
    send(8'hF0); expect_ev(10'h11C); send(8'h1C);
    drain("drain_repeat");

    // Overflow: 10 makes into an 8-deep stalled FIFO
    ovf_codes = '{8'h15, 8'h1D, 8'h24, 8'h2D, 8'h2C, 8'h35, 8'h3C, 8'h43, 8'h44, 8'h4D};
    ev_ready = 1'b0;
    kd_exp   = '0;
    for (int i = 0; i < 10; i++) begin
      if (i < 8) expect_ev({2'b00, ovf_codes[i]});
      kd_exp[{1'b0, ovf_codes[i]}] = 1'b1;
      send(ovf_codes[i]);
    end
    chk("ovf_level", fifo_level, 8);
    chk("ovf_count", ovf_count, 2);
    chk("ovf_key_down", key_down, kd_exp);
    chk("ovf_head_held", ev_data, 10'h015);
    ev_ready = 1'b1;
    drain("drain_ovf");

    // Reset mid-prefix
    send(8'hE0); send(8'hF0);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("midrst_key_down", key_down, 0);
    chk("midrst_kbd_ready", kbd_ready, 0);
    chk("midrst_ovf", ovf_count, 0);
    rst = 1'b1;
    send(8'hAA);
    expect_ev(10'h075); send(8'h75);
    chk("midrst_075_down", key_down[9'h075], 1);
    chk("midrst_175_down", key_down[9'h175], 0);
    chk("midrst_ovf_after", ovf_count, 0);
    drain("drain_final");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
